// File: rtl/thumb_inst_align_if.sv
// Fetch/decode handshake bundle for thumb_inst_align.
//   fetch_valid/fetch_data/fetch_ready : 32-bit code word stream from fetch
//   flush/flush_pc                     : discard buffered code, restart address
//   inst_valid/inst_ready              : instruction handshake towards decode
//   inst/inst_is32/inst_pc             : instruction, size flag, address
// slave  : the aligner side
// master : the fetch/decode environment side
interface thumb_inst_align_if;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        fetch_ready;
    logic        flush;
    logic [31:0] flush_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic        inst_is32;
    logic [31:0] inst_pc;

    modport slave (
        input  fetch_valid, fetch_data, flush, flush_pc, inst_ready,
        output fetch_ready, inst_valid, inst, inst_is32, inst_pc
    );

    modport master (
        output fetch_valid, fetch_data, flush, flush_pc, inst_ready,
        input  fetch_ready, inst_valid, inst, inst_is32, inst_pc
    );
endinterface

// File: rtl/thumb_inst_align.sv
// Thumb/Thumb-2 instruction aligner.
// Splits little-endian 32-bit fetch words into halfwords held in a 4-entry
// FIFO and presents one complete 16- or 32-bit instruction at a time.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : thumb_inst_align_if.slave (fetch side, flush, decode side)
module thumb_inst_align (
    input  logic                clk,
    input  logic                rst_n,
    thumb_inst_align_if.slave   bus
);

    logic [15:0] q [4];
    logic [1:0]  head;
    logic [1:0]  tail;
    logic [2:0]  count;
    logic [31:0] pc;
    logic        skip_lo;
    logic        live;       // low during and until the first edge after reset

    logic [15:0] h0;
    logic [15:0] h1;
    logic        head_is32;
    logic        valid;
    logic        push;
    logic        pop;
    logic [2:0]  push_n;
    logic [2:0]  pop_n;

    always_comb begin
        h0        = q[head];
        h1        = q[head + 2'd1];
        // 11101 / 11110 / 11111 prefixes mark a 32-bit encoding
        head_is32 = (h0[15:13] == 3'b111) && (h0[12:11] != 2'b00);
        valid     = head_is32 ? (count >= 3'd2) : (count >= 3'd1);

        bus.fetch_ready = live && (count <= 3'd2) && !bus.flush;
        bus.inst_valid  = valid;
        bus.inst_is32   = valid && head_is32;
        bus.inst_pc     = pc;
        if (!valid)
            bus.inst = '0;
        else if (head_is32)
            bus.inst = {h0, h1};
        else
            bus.inst = {h0, 16'h0000};

        push   = bus.fetch_valid && bus.fetch_ready;
        pop    = valid && bus.inst_ready && !bus.flush;
        push_n = push ? (skip_lo ? 3'd1 : 3'd2) : 3'd0;
        pop_n  = pop ? (head_is32 ? 3'd2 : 3'd1) : 3'd0;
    end

    // count<=2 whenever a push is accepted, so tail and tail+1 are free even
    // before any same-cycle pop is applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++)
                q[i] <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            pc      <= '0;
            skip_lo <= 1'b0;
            live    <= 1'b0;
        end else begin
            live <= 1'b1;
            if (bus.flush) begin
                head    <= '0;
                tail    <= '0;
                count   <= '0;
                pc      <= bus.flush_pc & 32'hFFFF_FFFE;
                skip_lo <= bus.flush_pc[1];
            end else begin
                if (push) begin
                    if (skip_lo) begin
                        q[tail] <= bus.fetch_data[31:16];
                    end else begin
                        q[tail]        <= bus.fetch_data[15:0];
                        q[tail + 2'd1] <= bus.fetch_data[31:16];
                    end
                    skip_lo <= 1'b0;
                end
                if (pop)
                    pc <= pc + (head_is32 ? 32'd4 : 32'd2);
                head  <= head + pop_n[1:0];
                tail  <= tail + push_n[1:0];
                count <= count + push_n - pop_n;
            end
        end
    end

endmodule

// File: tb/tb_thumb_inst_align.sv
// Self-checking bench for thumb_inst_align: directed scenarios plus random
// traffic compared every cycle against a halfword-queue reference model.
module tb_thumb_inst_align;

    logic clk;
    logic rst_n;

    thumb_inst_align_if bus ();

    thumb_inst_align dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // reference model state
    logic [15:0] hq [$];
    logic [31:0] m_pc;
    logic        m_skip;
    logic        m_alive;

    // DUT values observed in the most recent cycle
    logic [31:0] last_inst;
    logic [31:0] last_pc;
    logic        last_valid;
    logic        last_is32;
    logic        last_rdy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, compare outputs to
    // the model, then advance the model to the state after the next rising edge.
    task automatic cycle(input logic fv, input logic [31:0] fd, input logic fl,
                         input logic [31:0] fpc, input logic ir,
                         output logic acc, output logic popd);
        logic        e_rdy, e_is32, e_valid;
        logic [31:0] e_inst;
        @(negedge clk);
        bus.fetch_valid = fv;
        bus.fetch_data  = fd;
        bus.flush       = fl;
        bus.flush_pc    = fpc;
        bus.inst_ready  = ir;
        #1;
        e_rdy   = m_alive && (hq.size() <= 2) && !fl;
        e_is32  = (hq.size() > 0) && (hq[0][15:11] >= 5'd29);
        e_valid = hq.size() >= (e_is32 ? 2 : 1);
        if (!e_valid)
            e_inst = 32'h0;
        else if (e_is32)
            e_inst = {hq[0], hq[1]};
        else
            e_inst = {hq[0], 16'h0000};

        check("fetch_ready", {31'b0, bus.fetch_ready}, {31'b0, e_rdy});
        check("inst_valid",  {31'b0, bus.inst_valid},  {31'b0, e_valid});
        check("inst_is32",   {31'b0, bus.inst_is32},   {31'b0, e_valid && e_is32});
        check("inst",        bus.inst,    e_inst);
        check("inst_pc",     bus.inst_pc, m_pc);

        last_inst  = bus.inst;
        last_pc    = bus.inst_pc;
        last_valid = bus.inst_valid;
        last_is32  = bus.inst_is32;
        last_rdy   = bus.fetch_ready;

        acc  = fv && e_rdy;
        popd = e_valid && ir && !fl;
        if (fl) begin
            hq.delete();
            m_pc   = {fpc[31:1], 1'b0};
            m_skip = fpc[1];
        end else begin
            if (popd) begin
                void'(hq.pop_front());
                if (e_is32) void'(hq.pop_front());
                m_pc = m_pc + (e_is32 ? 32'd4 : 32'd2);
            end
            if (acc) begin
                if (!m_skip) hq.push_back(fd[15:0]);
                hq.push_back(fd[31:16]);
                m_skip = 1'b0;
            end
        end
    endtask

    // Holds reset across two falling edges, checks the reset outputs, then
    // releases; the model goes live because a rising edge precedes the next check.
    task automatic do_reset();
        rst_n = 1'b0;
        bus.fetch_valid = 1'b0;
        bus.fetch_data  = '0;
        bus.flush       = 1'b0;
        bus.flush_pc    = '0;
        bus.inst_ready  = 1'b0;
        hq.delete();
        m_pc    = '0;
        m_skip  = 1'b0;
        m_alive = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", {31'b0, bus.inst_valid},  32'd0);
        check("rst_ready", {31'b0, bus.fetch_ready}, 32'd0);
        check("rst_inst",  bus.inst,                 32'd0);
        check("rst_is32",  {31'b0, bus.inst_is32},   32'd0);
        check("rst_pc",    bus.inst_pc,              32'd0);
        rst_n   = 1'b1;
        m_alive = 1'b1;
    endtask

    function automatic logic [15:0] rand_first_hw(input logic is32);
        logic [15:0] h;
        h = 16'($urandom);
        if (is32)
            h[15:11] = 5'd29 + 5'($urandom_range(0, 2));
        else
            h[15:11] = 5'($urandom_range(0, 28));
        return h;
    endfunction

    logic        acc, pd;
    logic [15:0] sq [$];
    int          n_pop;

    initial begin
        n_checks = 0;
        n_errors = 0;
        do_reset();

        // two 16-bit instructions from one word
        cycle(0, 32'h0, 0, 32'h0, 1, acc, pd);
        check("ready_after_rst", {31'b0, last_rdy}, 32'd1);
        cycle(1, 32'h4408_4150, 0, 32'h0, 1, acc, pd);
        cycle(0, 32'h0, 0, 32'h0, 1, acc, pd);
        check("t16_first_inst", last_inst, 32'h4150_0000);
        check("t16_first_pc",   last_pc,   32'h0);
        cycle(0, 32'h0, 0, 32'h0, 1, acc, pd);
        check("t16_second_inst", last_inst, 32'h4408_0000);
        check("t16_second_pc",   last_pc,   32'h2);
        check("t16_second_is32", {31'b0, last_is32}, 32'd0);

        // 32-bit instruction split across words, starting at an odd halfword
        cycle(0, 32'h0, 1, 32'h102, 0, acc, pd);
        cycle(1, 32'hF101_1234, 0, 32'h0, 1, acc, pd);
        check("post_flush_valid", {31'b0, last_valid}, 32'd0);
        cycle(1, 32'h5678_0A05, 0, 32'h0, 1, acc, pd);
        check("split_wait_valid", {31'b0, last_valid}, 32'd0);
        cycle(0, 32'h0, 0, 32'h0, 1, acc, pd);
        check("split_inst", last_inst, 32'hF101_0A05);
        check("split_is32", {31'b0, last_is32}, 32'd1);
        check("split_pc",   last_pc, 32'h102);
        cycle(0, 32'h0, 0, 32'h0, 1, acc, pd);

        // flush colliding with push and pop
        cycle(1, 32'h1111_2222, 0, 32'h0, 0, acc, pd);
        cycle(1, 32'h3333_4444, 1, 32'h2001, 1, acc, pd);
        cycle(0, 32'h0, 0, 32'h0, 0, acc, pd);
        check("flush_valid", {31'b0, last_valid}, 32'd0);
        check("flush_pc",    last_pc, 32'h2000);

        // backpressure to full, then drain
        cycle(0, 32'h0, 1, 32'h0, 0, acc, pd);
        for (int i = 0; i < 6; i++)
            cycle(1, {16'($urandom), 16'h4000 + 16'(i)}, 0, 32'h0, 0, acc, pd);
        check("full_ready", {31'b0, last_rdy}, 32'd0);
        check("full_hold_inst", last_inst, 32'h4000_0000);
        for (int i = 0; i < 6; i++)
            cycle(0, 32'h0, 0, 32'h0, 1, acc, pd);

        // asynchronous reset with three halfwords buffered
        cycle(0, 32'h0, 1, 32'h2, 0, acc, pd);
        cycle(1, 32'h1111_4408, 0, 32'h0, 0, acc, pd);
        cycle(1, 32'h2222_3333, 0, 32'h0, 0, acc, pd);
        cycle(0, 32'h0, 0, 32'h0, 0, acc, pd);
        check("pre_rst_count", hq.size(), 32'd3);
        @(negedge clk);
        #2;
        check("pre_rst_valid", {31'b0, bus.inst_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'b0, bus.inst_valid},  32'd0);
        check("async_rst_ready", {31'b0, bus.fetch_ready}, 32'd0);
        check("async_rst_pc",    bus.inst_pc,              32'd0);
        do_reset();
        cycle(0, 32'h0, 0, 32'h0, 1, acc, pd);

        // stream of 64 mixed instructions through a pc wrap
        for (int i = 0; i < 64; i++) begin
            logic is32;
            is32 = 1'($urandom_range(0, 1));
            sq.push_back(rand_first_hw(is32));
            if (is32) sq.push_back(16'($urandom));
        end
        if (sq.size() % 2 != 0) sq.push_back(16'hBF00);
        cycle(0, 32'h0, 1, 32'hFFFF_FFF8, 0, acc, pd);
        n_pop = 0;
        for (int c = 0; c < 3000 && n_pop < 64; c++) begin
            logic        fv;
            logic [31:0] fd;
            fv = (sq.size() >= 2) && ($urandom_range(0, 9) < 7);
            fd = (sq.size() >= 2) ? {sq[1], sq[0]} : 32'h0;
            cycle(fv, fd, 0, 32'h0, 1'($urandom_range(0, 9) < 7), acc, pd);
            if (acc) begin
                void'(sq.pop_front());
                void'(sq.pop_front());
            end
            if (pd) n_pop++;
        end
        check("stream_pops", n_pop, 32'd64);

        // unconstrained random traffic with occasional flushes
        for (int c = 0; c < 500; c++) begin
            logic [31:0] d;
            d = $urandom;
            if ($urandom_range(0, 1) == 1)
                d[15:11] = 5'd29 + 5'($urandom_range(0, 2));
            cycle(1'($urandom_range(0, 1)), d, $urandom_range(0, 19) == 0,
                  $urandom, 1'($urandom_range(0, 1)), acc, pd);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
